// File: rtl/inbox_fifo_if.sv
// inbox_fifo_if: bundle of the inbox host/CPU signals.
//   master modport : host/loader and CPU side (drives strobes and write data)
//   slave modport  : the inbox itself (drives head word, status and flags)
// Signals:
//   wr_en, wr_data     host write strobe and data
//   rIn                CPU pop strobe
//   rewind, commit     replay controls
//   clear              flush pointers and flags
//   DIN                head word, 0 when empty
//   empty, full, count occupancy status
//   overflow/underflow sticky error flags
interface inbox_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rIn;
  logic              rewind;
  logic              commit;
  logic              clear;
  logic [DATA_W-1:0] DIN;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rIn, rewind, commit, clear,
    input  DIN, empty, full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rIn, rewind, commit, clear,
    output DIN, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/inbox_fifo.sv
// inbox_fifo: circular buffer filled by the host, drained one word per rIn
// pulse by the CPU. First-word fall-through: DIN always shows the head word
// (0 while empty). With REPLAY=1, popped words stay resident until commit,
// so rewind can replay them without reloading.
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : synchronous active-high reset (pointers and flags only)
//   bus  : inbox_fifo_if.slave (strobes in; DIN/status/flags out)
// DEPTH must be a power of two and at least 2.
module inbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int REPLAY = 0
) (
  input logic         clk,
  input logic         rst,
  inbox_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam bit REPLAY_EN = (REPLAY != 0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

  // Pointers carry one extra wrap bit so count/used distinguish full from empty.
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  mark_ptr_reg, mark_ptr_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  used;
  logic              empty;
  logic              full;
  logic              wr_accept;

  // count = unread words; used = words still occupying storage (unread plus
  // replay-retained). Only used decides whether a write fits.
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign used  = wr_ptr_reg - mark_ptr_reg;
  assign empty = (count == '0);
  assign full  = (used == PTR_DEPTH);

  // Full is the pre-edge value: a pop in the same cycle does not make room.
  assign wr_accept = bus.wr_en && !full && !bus.clear && !rst;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    mark_ptr_next  = mark_ptr_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (bus.clear) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      mark_ptr_next  = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      // Writes run alongside rewind/commit/pop.
      if (bus.wr_en) begin
        if (!full) begin
          wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end else begin
          overflow_next = 1'b1;
        end
      end

      if (REPLAY_EN && bus.rewind) begin
        // Rewind wins over commit and swallows a same-cycle pop entirely.
        rd_ptr_next = mark_ptr_reg;
      end else begin
        // Commit uses the pre-pop read pointer; a same-cycle pop still happens.
        if (REPLAY_EN && bus.commit) begin
          mark_ptr_next = rd_ptr_reg;
        end
        if (bus.rIn) begin
          if (!empty) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
            // Without replay, consumed words are freed immediately.
            if (!REPLAY_EN) begin
              mark_ptr_next = rd_ptr_reg + PTR_ONE;
            end
          end else begin
            // Empty is pre-edge: a word landing this cycle does not satisfy it.
            underflow_next = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mark_ptr_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      mark_ptr_reg  <= mark_ptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is not reset; pointer reset alone makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  // Fall-through read: asynchronous lookup of the head, forced to 0 when empty.
  assign bus.DIN       = empty ? '0 : mem[rd_ptr_reg[ADDR_W-1:0]];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_inbox_fifo.sv
// tb_inbox_fifo: drives a plain (REPLAY=0) and a replay (REPLAY=1) inbox,
// both DEPTH=4, from shared write/pop/clear stimulus; rewind/commit go to
// the replay instance only. A queue-based model predicts every output and is
// compared on each falling edge; literal checks pin the test-plan values.
module tb_inbox_fifo;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rin = 1'b0;
  logic         clr = 1'b0;
  logic         rw = 1'b0;
  logic         cm = 1'b0;

  inbox_fifo_if #(.DATA_W(W), .DEPTH(D)) b0 ();
  inbox_fifo_if #(.DATA_W(W), .DEPTH(D)) b1 ();

  assign b0.wr_en   = wr_en;
  assign b0.wr_data = wr_data;
  assign b0.rIn     = rin;
  assign b0.clear   = clr;
  assign b0.rewind  = 1'b0;
  assign b0.commit  = 1'b0;
  assign b1.wr_en   = wr_en;
  assign b1.wr_data = wr_data;
  assign b1.rIn     = rin;
  assign b1.clear   = clr;
  assign b1.rewind  = rw;
  assign b1.commit  = cm;

  inbox_fifo #(.DATA_W(W), .DEPTH(D), .REPLAY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  inbox_fifo #(.DATA_W(W), .DEPTH(D), .REPLAY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  logic [W-1:0] din_a [2];
  logic [2:0]   cnt_a [2];
  logic         emp_a [2];
  logic         ful_a [2];
  logic         ovf_a [2];
  logic         udf_a [2];
  assign din_a[0] = b0.DIN;   assign din_a[1] = b1.DIN;
  assign cnt_a[0] = b0.count; assign cnt_a[1] = b1.count;
  assign emp_a[0] = b0.empty; assign emp_a[1] = b1.empty;
  assign ful_a[0] = b0.full;  assign ful_a[1] = b1.full;
  assign ovf_a[0] = b0.overflow;  assign ovf_a[1] = b1.overflow;
  assign udf_a[0] = b1.underflow === 1'bx ? 1'b0 : b0.underflow; assign udf_a[1] = b1.underflow;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, k, $time, act, exp);
    end
  endtask

  // Model: per instance, a queue of resident words (oldest first) and the
  // number of those already consumed (always 0 without replay).
  logic [W-1:0] mq [2][$];
  int           roff [2];
  bit           movf [2];
  bit           mudf [2];
  bit           mvalid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit krw, kcm, pre_emp, pre_ful;
      krw = (k == 1) && rw;
      kcm = (k == 1) && cm;
      if (rst || clr) begin
        mq[k].delete();
        roff[k] = 0;
        movf[k] = 1'b0;
        mudf[k] = 1'b0;
      end else begin
        pre_emp = (mq[k].size() - roff[k]) == 0;
        pre_ful = mq[k].size() == D;
        if (krw) begin
          roff[k] = 0;
        end else begin
          if (kcm) begin
            for (int j = 0; j < roff[k]; j++) void'(mq[k].pop_front());
            roff[k] = 0;
          end
          if (rin) begin
            if (pre_emp) mudf[k] = 1'b1;
            else if (k == 1) roff[k]++;
            else void'(mq[k].pop_front());
          end
        end
        if (wr_en) begin
          if (pre_ful) movf[k] = 1'b1;
          else mq[k].push_back(wr_data);
        end
      end
    end
    if (rst) mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        int c;
        logic [W-1:0] h;
        c = mq[k].size() - roff[k];
        h = (c == 0) ? '0 : mq[k][roff[k]];
        check("din",   k, din_a[k], h);
        check("count", k, cnt_a[k], c);
        check("empty", k, emp_a[k], c == 0);
        check("full",  k, ful_a[k], mq[k].size() == D);
        check("ovf",   k, ovf_a[k], movf[k]);
        check("udf",   k, udf_a[k], mudf[k]);
      end
    end
  end

  // One clock of stimulus; inputs return to idle 2 time units after the edge.
  task automatic cyc(input bit we, input logic [W-1:0] d, input bit r,
                     input bit c, input bit rwd, input bit cmt);
    wr_en = we; wr_data = d; rin = r; clr = c; rw = rwd; cm = cmt;
    @(posedge clk);
    #2;
    wr_en = 1'b0; wr_data = '0; rin = 1'b0; clr = 1'b0; rw = 1'b0; cm = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] d); cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic pop();                     cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); endtask

  logic [W-1:0] exp_seq [4];

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    check("rst_din",   0, b0.DIN, 8'h00);
    check("rst_empty", 0, b0.empty, 1'b1);
    check("rst_count", 0, b0.count, 3'd0);
    check("rst_flags", 1, {b1.full, b1.overflow, b1.underflow}, 3'b000);

    // Basic fill and drain.
    wr(8'h11); wr(8'h22); wr(8'h33);
    check("t1_count", 0, b0.count, 3'd3);
    check("t1_din0",  0, b0.DIN, 8'h11);
    pop(); check("t1_din1", 0, b0.DIN, 8'h22);
    pop(); check("t1_din2", 0, b0.DIN, 8'h33);
    pop(); check("t1_empty", 0, b0.empty, 1'b1);
    check("t1_din3", 0, b0.DIN, 8'h00);

    // Overflow and wrap-around.
    wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h44);
    wr(8'h55);
    check("t2_full", 0, b0.full, 1'b1);
    check("t2_ovf",  0, b0.overflow, 1'b1);
    check("t2_cnt",  0, b0.count, 3'd4);
    check("t2_head", 0, b0.DIN, 8'h41);
    pop();
    wr(8'h66);
    check("t2_cnt2", 0, b0.count, 3'd4);
    exp_seq[0] = 8'h42; exp_seq[1] = 8'h43; exp_seq[2] = 8'h44; exp_seq[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      check("t2_order", 0, b0.DIN, exp_seq[i]);
      pop();
    end

    // Underflow with a simultaneous write: no bypass.
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_udf", 0, b0.underflow, 1'b1);
    check("t3_cnt", 0, b0.count, 3'd1);
    check("t3_din", 0, b0.DIN, 8'h77);
    pop();

    // Replay: rewind and commit.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_clr_empty", 1, b1.empty, 1'b1);
    check("t4_clr_udf",   1, b1.underflow, 1'b0);
    wr(8'hA0); wr(8'hA1); wr(8'hA2); wr(8'hA3);
    pop(); pop(); pop();
    check("t4_din3", 1, b1.DIN, 8'hA3);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_rw_din", 1, b1.DIN, 8'hA0);
    check("t4_rw_cnt", 1, b1.count, 3'd4);
    pop(); pop();
    check("t4_full_pre", 1, b1.full, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_cm_full", 1, b1.full, 1'b0);
    check("t4_cm_cnt",  1, b1.count, 3'd2);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_rw2_din", 1, b1.DIN, 8'hA2);

    // Replay corner cases.
    pop();
    check("t5_din", 1, b1.DIN, 8'hA3);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_rwr_din", 1, b1.DIN, 8'hA2);
    check("t5_rwr_cnt", 1, b1.count, 3'd2);
    check("t5_rwr_udf", 1, b1.underflow, 1'b0);
    pop();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_cmrw_din", 1, b1.DIN, 8'hA2);
    check("t5_cmrw_cnt", 1, b1.count, 3'd2);
    pop();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_cmr_empty", 1, b1.empty, 1'b1);
    check("t5_cmr_udf",   1, b1.underflow, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_mark_din", 1, b1.DIN, 8'hA3);
    check("t5_mark_cnt", 1, b1.count, 3'd1);

    // Mixed traffic, checked by the model only.
    for (int i = 0; i < 48; i++) begin
      cyc((i % 3) != 0, 8'(8'hC0 + i), (i % 2) == 0, 1'b0, (i % 11) == 5, (i % 7) == 3);
    end

    // Clear mid-stream with a write, then reset after flags are set.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) wr(8'h90 + 8'(i));
    check("t6_ovf", 0, b0.overflow, 1'b1);
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_clr_empty", 0, b0.empty, 1'b1);
    check("t6_clr_ovf",   0, b0.overflow, 1'b0);
    check("t6_clr_din",   0, b0.DIN, 8'h00);
    pop();
    check("t6_udf", 0, b0.underflow, 1'b1);
    wr(8'h21);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hBB;
    @(posedge clk);
    #2;
    rst = 1'b0; wr_en = 1'b0; wr_data = '0;
    check("t6_rst_empty", 0, b0.empty, 1'b1);
    check("t6_rst_udf",   0, b0.underflow, 1'b0);
    check("t6_rst_cnt",   0, b0.count, 3'd0);
    check("t6_rst_empty", 1, b1.empty, 1'b1);
    @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inbox_fifo.md
# inbox_fifo

Parametrised successor to the CPU inbox: a circular buffer the host/loader fills with level input values, and the CPU drains one word per `rIn` pulse. Generalises the fixed 8-bit inbox to configurable width and depth. Adds a host write port, full/occupancy status, sticky error flags, and an optional replay mode in which consumed words are kept until committed, so a level can be re-run without reloading.

## Interface
- `DATA_W`, 8, width of each inbox word.
- `DEPTH`, 16, number of entries; must be a power of two, ≥2; `ADDR_W = log2(DEPTH)`.
- `REPLAY`, 0, 0 = reads free entries immediately; 1 = reads retain entries until `commit`.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host write strobe; one word per cycle.
- `wr_data`  in  DATA_W  host write data.
- `rIn`  in  1  CPU read (pop) strobe.
- `DIN`  out  DATA_W  head word (first-word fall-through); 0 when `empty`.
- `empty`  out  1  no unread words.
- `full`  out  1  no free entry for a write.
- `count`  out  ADDR_W+1  unread words, 0..DEPTH.
- `rewind`  in  1  replay only: read pointer returns to mark.
- `commit`  in  1  replay only: mark advances to read pointer, freeing consumed words.
- `clear`  in  1  flush all contents and flags.
- `overflow`  out  1  sticky: write attempted while `full`.
- `underflow`  out  1  sticky: `rIn` while `empty`.

## Operation
- State: `wr_ptr`, `rd_ptr`, `mark_ptr`, each ADDR_W+1 bits (extra wrap bit); memory `DEPTH x DATA_W`.
- Derived (pre-edge state): `count = wr_ptr - rd_ptr`; `used = wr_ptr - mark_ptr`; `empty = (count==0)`; `full = (used==DEPTH)`. Arithmetic is modulo 2^(ADDR_W+1); addresses use low ADDR_W bits, so wrap-around is implicit.
- REPLAY=0: `mark_ptr` tracks `rd_ptr` on every pop; `rewind`, `commit` ignored.
- REPLAY=1: `rd_ptr` advances on pop, `mark_ptr` only on `commit`; `rewind` sets `rd_ptr=mark_ptr`.
- Write: `wr_en & !full` stores `wr_data` at `wr_ptr`, increments `wr_ptr`. `wr_en & full`: data dropped, `overflow` set.
- Read: `rIn & !empty` increments `rd_ptr`. `rIn & empty`: no change, `underflow` set.
- Priority per cycle: `rst` > `clear` > `rewind` > `commit` > normal read; writes proceed alongside everything except `rst`/`clear`.
  - `clear`: all pointers 0, flags 0, same-cycle write dropped.
  - `rewind`: same-cycle `rIn` ignored (no underflow); `commit` ignored; write accepted.
  - `commit` with `rIn`: mark takes the pre-pop `rd_ptr`; pop still occurs.
- Simultaneous write+read: both evaluated against pre-edge flags; write while full is dropped even if a read frees space that cycle; read while empty flags underflow even if a write lands that cycle (no bypass).
- Memory contents are not reset; only pointers and flags.

## Timing
- Reset values: `DIN=0`, `empty=1`, `full=0`, `count=0`, `overflow=0`, `underflow=0`.
- `DIN` is combinational from `mem[rd_ptr]`, gated by `empty`; valid in the same cycle `empty` is low.
- Write latency: a word written at edge N is visible on `DIN` and `count` after edge N.
- Pop: `DIN` shows the next word after the edge that sampled `rIn`; the CPU latches `DIN` in the cycle it asserts `rIn`.
- Flags, `count`, `full`, `empty` update one edge after the causing strobe; no combinational path from strobes to outputs.
- `rst`/`clear` mid-operation: takes effect at that edge regardless of other inputs.

## Test plan
- Reset, DEPTH=4: write 0x11,0x22,0x33 → `count=3`, `DIN=0x11`; three `rIn` → `DIN` 0x22, 0x33, then `empty=1`, `DIN=0`.
- Fill 4 then write 0x55 → `full=1`, `overflow=1`, 0x55 absent; pop one, write 0x66 → accepted, wraps to entry 0, read order preserved.
- `rIn` on empty with simultaneous write 0x77 → `underflow=1`, `count=1`, `DIN=0x77` next cycle.
- REPLAY=1: load 0xA0..0xA3, pop 3, `rewind` → `DIN=0xA0`, `count=4`; pop 2, `commit` → `full=0` with `used=2`, then `rewind` → `DIN=0xA2`.
- REPLAY=1 `rewind`+`rIn` same cycle → `rd_ptr=mark`, no pop, no underflow; `commit`+`rewind` → mark unchanged.
- `clear` with `wr_en` mid-stream, then `rst` after flags set → pointers 0, flags 0, `empty=1`, dropped write not visible.
